// File: rtl/baby_vga_timing_gen.sv
// Raster timing generator for the baby VGA peripheral.
// Produces sync, blanking and 32x16 cell coordinates, a free-running framebuffer
// read-phase counter and a sticky vertical-blank interrupt. Every output is a
// register, so each one shows the raster position of the previous clock.
module baby_vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned H_FP     = 24,
   parameter int unsigned H_SYNC   = 136,
   parameter int unsigned H_BP     = 160,
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned V_FP     = 3,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 29,
   parameter int unsigned CELL_W   = 32,
   parameter int unsigned CELL_H   = 48,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cli,
   output logic [4:0] x_pos,
   output logic [3:0] y_pos,
   output logic       hsync,
   output logic       vsync,
   output logic       blank,
   output logic [2:0] counter,
   output logic       interrupt
);

   localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW    = $clog2(H_TOT);
   localparam int unsigned VW    = $clog2(V_TOT);
   localparam int unsigned CW    = (CELL_W > 1) ? $clog2(CELL_W) : 1;
   localparam int unsigned RW    = (CELL_H > 1) ? $clog2(CELL_H) : 1;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_ON  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
   localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_ON  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] C_LAST     = CW'(CELL_W - 1);
   localparam logic [RW-1:0] R_LAST     = RW'(CELL_H - 1);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic [CW-1:0] col_sub_q, col_sub_d;
   logic [4:0]    col_q, col_d;
   logic [RW-1:0] row_sub_q, row_sub_d;
   logic [3:0]    row_q, row_d;
   logic          int_q, int_d;
   logic [2:0]    counter_q;
   logic [4:0]    x_pos_q, x_pos_d;
   logic [3:0]    y_pos_q, y_pos_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          blank_q, blank_d;
   logic          h_last, h_vis, v_vis;

   assign h_last = (h_cnt_q >= H_LAST);
   assign h_vis  = (h_cnt_q < H_ACT);
   assign v_vis  = (v_cnt_q < V_ACT);

   // Raster and cell counter next state; out-of-range values fall back to 0.
   always_comb begin
      h_cnt_d   = h_last ? '0 : h_cnt_q + 1'b1;
      v_cnt_d   = v_cnt_q;
      col_sub_d = col_sub_q;
      col_d     = col_q;
      row_sub_d = row_sub_q;
      row_d     = row_q;

      if (v_cnt_q > V_LAST) begin
         v_cnt_d = '0;
      end else if (h_last) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end

      // Column wraps 31->0 at the end of the active span; blanking holds it at 0.
      if (!h_vis) begin
         col_sub_d = '0;
         col_d     = '0;
      end else if (col_sub_q >= C_LAST) begin
         col_sub_d = '0;
         col_d     = col_q + 5'd1;
      end else begin
         col_sub_d = col_sub_q + 1'b1;
      end

      // Rows advance on the last clock of a visible line; vblank parks row 0.
      if (!v_vis) begin
         row_sub_d = '0;
         row_d     = '0;
      end else if (row_sub_q > R_LAST) begin
         row_sub_d = '0;
      end else if (h_last) begin
         if (row_sub_q == R_LAST) begin
            row_sub_d = '0;
            row_d     = row_q + 4'd1;
         end else begin
            row_sub_d = row_sub_q + 1'b1;
         end
      end
   end

   // Output and interrupt next state; a set on the same clock as cli wins.
   always_comb begin
      blank_d = !(h_vis && v_vis);
      hsync_d = (h_cnt_q >= H_SYNC_ON && h_cnt_q < H_SYNC_OFF) ? SYNC_POL : !SYNC_POL;
      vsync_d = (v_cnt_q >= V_SYNC_ON && v_cnt_q < V_SYNC_OFF) ? SYNC_POL : !SYNC_POL;
      x_pos_d = h_vis ? col_q : '0;
      y_pos_d = v_vis ? row_q : '0;
      int_d   = int_q;
      if (h_cnt_q == '0 && v_cnt_q == V_ACT) begin
         int_d = 1'b1;
      end else if (cli) begin
         int_d = 1'b0;
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         col_sub_q <= '0;
         col_q     <= '0;
         row_sub_q <= '0;
         row_q     <= '0;
         int_q     <= 1'b0;
         counter_q <= 3'd0;
         x_pos_q   <= '0;
         y_pos_q   <= '0;
         hsync_q   <= !SYNC_POL;
         vsync_q   <= !SYNC_POL;
         blank_q   <= 1'b1;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         col_sub_q <= col_sub_d;
         col_q     <= col_d;
         row_sub_q <= row_sub_d;
         row_q     <= row_d;
         int_q     <= int_d;
         counter_q <= counter_q + 3'd1;
         x_pos_q   <= x_pos_d;
         y_pos_q   <= y_pos_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         blank_q   <= blank_d;
      end
   end

   assign x_pos     = x_pos_q;
   assign y_pos     = y_pos_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign blank     = blank_q;
   assign counter   = counter_q;
   assign interrupt = int_q;

endmodule

// File: tb/tb_baby_vga_timing_gen.sv
// Directed bench: default 1024x768 timing for line-level checks, and a small
// 80x36 configuration for frame-level, interrupt and reset checks.
module tb_baby_vga_timing_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cli = 1'b0;

   logic [4:0] d_x, f_x;
   logic [3:0] d_y, f_y;
   logic       d_hs, d_vs, d_bl, d_int;
   logic       f_hs, f_vs, f_bl, f_int;
   logic [2:0] d_cnt, f_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   baby_vga_timing_gen d_dut (
      .clk       (clk),
      .rst       (rst),
      .cli       (cli),
      .x_pos     (d_x),
      .y_pos     (d_y),
      .hsync     (d_hs),
      .vsync     (d_vs),
      .blank     (d_bl),
      .counter   (d_cnt),
      .interrupt (d_int)
   );

   baby_vga_timing_gen #(
      .H_ACTIVE (64),
      .H_FP     (4),
      .H_SYNC   (8),
      .H_BP     (4),
      .V_ACTIVE (32),
      .V_FP     (1),
      .V_SYNC   (2),
      .V_BP     (1),
      .CELL_W   (2),
      .CELL_H   (2),
      .SYNC_POL (1'b0)
   ) f_dut (
      .clk       (clk),
      .rst       (rst),
      .cli       (cli),
      .x_pos     (f_x),
      .y_pos     (f_y),
      .hsync     (f_hs),
      .vsync     (f_vs),
      .blank     (f_bl),
      .counter   (f_cnt),
      .interrupt (f_int)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_d_x"}, d_x, 0);
      check({tag, "_d_y"}, d_y, 0);
      check({tag, "_d_hs"}, d_hs, 1);
      check({tag, "_d_vs"}, d_vs, 1);
      check({tag, "_d_bl"}, d_bl, 1);
      check({tag, "_d_cnt"}, d_cnt, 0);
      check({tag, "_d_int"}, d_int, 0);
      check({tag, "_f_x"}, f_x, 0);
      check({tag, "_f_y"}, f_y, 0);
      check({tag, "_f_hs"}, f_hs, 1);
      check({tag, "_f_vs"}, f_vs, 1);
      check({tag, "_f_bl"}, f_bl, 1);
      check({tag, "_f_cnt"}, f_cnt, 0);
      check({tag, "_f_int"}, f_int, 0);
   endtask

   initial begin
      int d_rise0, d_rise1, d_bfall, d_hs_fall, d_hs_rise;
      int f_vs_fall0, f_vs_fall1, f_vs_rise, f_hs_fall, f_hs_rise, f_rise;
      int cnt_err;
      logic d_bl_p, d_hs_p, f_vs_p, f_hs_p, f_bl_p;

      d_rise0 = -1; d_rise1 = -1; d_bfall = -1; d_hs_fall = -1; d_hs_rise = -1;
      f_vs_fall0 = -1; f_vs_fall1 = -1; f_vs_rise = -1; f_hs_fall = -1; f_hs_rise = -1;
      f_rise = -1;
      cnt_err = 0;

      repeat (3) tick();
      check_reset_values("rst");
      rst = 1'b0;

      d_bl_p = 1'b1; d_hs_p = 1'b1; f_vs_p = 1'b1; f_hs_p = 1'b1;
      // Sample k shows the raster position k-1 counted from release.
      for (int k = 1; k <= 5600; k++) begin
         tick();
         if (d_cnt != 3'(k)) cnt_err++;
         if (f_cnt != 3'(k)) cnt_err++;

         if (d_bl && !d_bl_p) begin
            if (d_rise0 < 0) d_rise0 = k;
            else if (d_rise1 < 0) d_rise1 = k;
         end
         if (!d_bl && d_bl_p && d_rise0 >= 0 && d_bfall < 0) d_bfall = k;
         if (!d_hs && d_hs_p && d_hs_fall < 0) d_hs_fall = k;
         if (d_hs && !d_hs_p && d_hs_rise < 0) d_hs_rise = k;
         if (!f_vs && f_vs_p) begin
            if (f_vs_fall0 < 0) f_vs_fall0 = k;
            else if (f_vs_fall1 < 0) f_vs_fall1 = k;
         end
         if (f_vs && !f_vs_p && f_vs_rise < 0) f_vs_rise = k;
         if (!f_hs && f_hs_p && f_hs_fall < 0) f_hs_fall = k;
         if (f_hs && !f_hs_p && f_hs_rise < 0) f_hs_rise = k;
         d_bl_p = d_bl; d_hs_p = d_hs; f_vs_p = f_vs; f_hs_p = f_hs;

         if (k == 1) begin
            check("first_blank", d_bl, 0);
            check("first_x", d_x, 0);
            check("first_y", d_y, 0);
            check("first_hs", d_hs, 1);
            check("first_vs", d_vs, 1);
         end
         if (k == 32)   check("d_x_pos31", d_x, 0);
         if (k == 33)   check("d_x_pos32", d_x, 1);
         if (k == 1024) check("d_x_pos1023", d_x, 31);
         if (k == 1025) check("d_x_hblank", d_x, 0);
         if (k == 2)    check("f_x_pos1", f_x, 0);
         if (k == 3)    check("f_x_pos2", f_x, 1);
         if (k == 64)   check("f_x_pos63", f_x, 31);
         if (k == 65)   check("f_x_hblank", f_x, 0);
         if (k == 91)   check("f_y_line1", f_y, 0);
         if (k == 171)  check("f_y_line2", f_y, 1);
         if (k == 2491) check("f_y_line31", f_y, 15);
         if (k == 2571) begin
            check("f_y_vblank", f_y, 0);
            check("f_bl_vblank", f_bl, 1);
         end
         if (k == 2891) check("f_y_frame2_line0", f_y, 0);
         if (k == 3131) check("f_y_frame2_line3", f_y, 1);
         if (k == 2560) check("int_before_set", f_int, 0);
         if (k == 2561) check("int_set", f_int, 1);
         if (k == 2700) check("int_sticky", f_int, 1);
         if (k == 2801) begin
            check("int_cleared", f_int, 0);
            cli = 1'b0;
         end
         if (k == 2802) check("int_stays_clear", f_int, 0);
         if (k == 5440) check("int_clear_before_set2", f_int, 0);
         if (k == 5441) begin
            check("int_set_wins", f_int, 1);
            cli = 1'b0;
         end
         if (k == 5442) check("int_after_coincide", f_int, 1);
         if (k == 2800 || k == 5440) cli = 1'b1;
      end

      check("d_blank_low_run", d_rise0 - 1, 1024);
      check("d_blank_high_run", d_bfall - d_rise0, 320);
      check("d_line_period", d_rise1 - d_rise0, 1344);
      check("d_hs_offset", d_hs_fall - d_rise0, 24);
      check("d_hs_width", d_hs_rise - d_hs_fall, 136);
      check("f_hs_start", f_hs_fall, 69);
      check("f_hs_width", f_hs_rise - f_hs_fall, 8);
      check("f_vs_start", f_vs_fall0, 2641);
      check("f_vs_width", f_vs_rise - f_vs_fall0, 160);
      check("f_frame_period", f_vs_fall1 - f_vs_fall0, 2880);
      check("d_int_never", d_int, 0);

      // Mid-frame reset: fast config is in vsync with interrupt set here.
      check("pre_rst_f_vs", f_vs, 0);
      check("pre_rst_f_int", f_int, 1);
      rst = 1'b1;
      #1;
      check_reset_values("async");
      repeat (3) tick();
      check_reset_values("held");
      rst = 1'b0;

      f_bl_p = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (d_cnt != 3'(k)) cnt_err++;
         if (f_cnt != 3'(k)) cnt_err++;
         if (f_bl && !f_bl_p && f_rise < 0) f_rise = k;
         f_bl_p = f_bl;
         if (k == 1) begin
            check("restart_f_bl", f_bl, 0);
            check("restart_f_hs", f_hs, 1);
            check("restart_f_vs", f_vs, 1);
            check("restart_f_y", f_y, 0);
            check("restart_d_bl", d_bl, 0);
         end
      end
      check("restart_f_blank_rise", f_rise, 65);
      check("restart_f_int", f_int, 0);
      check("counter_seq", cnt_err, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
